// File: rtl/instruction_fetch_buffer.sv
// Fetch stage: drives a line address to instruction memory, waits out the
// multi-cycle line read, buffers the 64-bit line and hands its four 16-bit
// instructions to decode one at a time over a valid/ready handshake.
// A branch redirect discards the buffered line and restarts fetch.
module instruction_fetch_buffer #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FETCH_WAIT = 6
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [63:0] imem_line,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready
);

  localparam int                CNT_W    = $clog2(FETCH_WAIT);
  localparam logic [CNT_W-1:0]  WAIT_END = CNT_W'(FETCH_WAIT - 1);

  typedef enum logic {WAIT, ISSUE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [1:0]         slot;
  logic [63:0]        line_buf;

  // Byte 0 of a line is the most significant byte, so slot 0 sits in [63:48].
  function automatic logic [15:0] slot_sel(input logic [63:0] line, input logic [1:0] s);
    case (s)
      2'd0:    slot_sel = line[63:48];
      2'd1:    slot_sel = line[47:32];
      2'd2:    slot_sel = line[31:16];
      default: slot_sel = line[15:0];
    endcase
  endfunction

  // Byte-offset bit of a PC is meaningless for 16-bit instructions.
  logic unused_pc_bit;
  assign unused_pc_bit = redirect_pc[0];

  logic handshake;
  assign handshake = instr_valid & instr_ready;

  // Fetch control: reset, then redirect, then the WAIT/ISSUE sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_addr   <= {RESET_PC[15:3], 3'b000};
      slot        <= RESET_PC[2:1];
      instr_valid <= 1'b0;
      instr       <= 16'h0000;
      instr_pc    <= 16'h0000;
      wait_cnt    <= '0;
      state       <= WAIT;
    end else if (redirect_valid) begin
      // Any instruction accepted this same cycle is already consumed by decode;
      // nothing more from the old line is presented.
      imem_addr   <= {redirect_pc[15:3], 3'b000};
      slot        <= redirect_pc[2:1];
      instr_valid <= 1'b0;
      wait_cnt    <= '0;
      state       <= WAIT;
    end else begin
      case (state)
        WAIT: begin
          if (wait_cnt == WAIT_END) begin
            line_buf    <= imem_line;
            instr       <= slot_sel(imem_line, slot);
            instr_pc    <= {imem_addr[15:3], slot, 1'b0};
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ISSUE: begin
          if (handshake) begin
            if (slot != 2'd3) begin
              slot     <= slot + 2'd1;
              instr    <= slot_sel(line_buf, slot + 2'd1);
              instr_pc <= {imem_addr[15:3], slot + 2'd1, 1'b0};
            end else begin
              // Last slot consumed: move to the next sequential line (wraps at 64K).
              instr_valid <= 1'b0;
              imem_addr   <= imem_addr + 16'd8;
              slot        <= 2'd0;
              wait_cnt    <= '0;
              state       <= WAIT;
            end
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule
